// File: rtl/rr_req_gnt_arbiter_if.sv
// Request/grant bundle between requesting agents and the round-robin arbiter.
// The master modport is the requester side and the slave modport is the arbiter side.
interface rr_req_gnt_arbiter_if #(
    parameter int N   = 4,
    parameter int IDW = (N > 1) ? $clog2(N) : 1
);
    logic [N-1:0]   req;
    logic           lock;
    logic [N-1:0]   gnt;
    logic           gnt_valid;
    logic [IDW-1:0] gnt_id;
    logic [7:0]     hold_cnt;

    modport master (
        output req,
        output lock,
        input  gnt,
        input  gnt_valid,
        input  gnt_id,
        input  hold_cnt
    );

    modport slave (
        input  req,
        input  lock,
        output gnt,
        output gnt_valid,
        output gnt_id,
        output hold_cnt
    );
endinterface

// File: rtl/rr_req_gnt_arbiter.sv
// Round-robin req/gnt arbiter: one owner at a time, registered one-hot grant
// one cycle after the request, with a MAX_HOLD burst limit that lock can override.
module rr_req_gnt_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 4,
    parameter int IDW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    rr_req_gnt_arbiter_if.slave  bus
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    state_t         state_q,    state_d;
    logic [N-1:0]   gnt_q,      gnt_d;
    logic           gnt_vld_q,  gnt_vld_d;
    logic [IDW-1:0] gnt_id_q,   gnt_id_d;
    logic [IDW-1:0] last_q,     last_d;
    logic [7:0]     hold_cnt_q, hold_cnt_d;

    // First requester found scanning upward from (from+1) mod N with wrap-around.
    function automatic logic [IDW-1:0] pick_next(input logic [N-1:0] r,
                                                 input logic [IDW-1:0] from);
        logic [IDW-1:0] idx;
        logic           found;
        int             cand;
        idx   = from;
        found = 1'b0;
        for (int off = 1; off <= N; off++) begin
            cand = (int'(from) + off) % N;
            if (!found && r[IDW'(cand)]) begin
                idx   = IDW'(cand);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    // Saturating increment of the hold counter.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : v + 8'd1;
    endfunction

    logic [IDW-1:0] pick;
    logic           any_req;
    logic           others_pending;
    logic           owner_req;
    logic           burst_expired;

    // Next-state decision: who owns the resource after this edge.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_vld_d  = gnt_vld_q;
        gnt_id_d   = gnt_id_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;

        // last_q always equals the owner while in OWN, so one scan serves both states.
        pick           = pick_next(bus.req, last_q);
        any_req        = |bus.req;
        others_pending = |(bus.req & ~gnt_q);
        owner_req      = |(bus.req & gnt_q);
        burst_expired  = (MAX_HOLD != 0) && (int'(hold_cnt_q) >= MAX_HOLD);

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d     = ST_OWN;
                    gnt_d       = '0;
                    gnt_d[pick] = 1'b1;
                    gnt_vld_d   = 1'b1;
                    gnt_id_d    = pick;
                    last_d      = pick;
                    hold_cnt_d  = 8'd1;
                end else begin
                    gnt_d      = '0;
                    gnt_vld_d  = 1'b0;
                    hold_cnt_d = 8'd0;
                end
            end
            ST_OWN: begin
                if ((!owner_req && others_pending) ||
                    (owner_req && burst_expired && !bus.lock && others_pending)) begin
                    // Hand off back-to-back to the next requester in rotation.
                    gnt_d       = '0;
                    gnt_d[pick] = 1'b1;
                    gnt_vld_d   = 1'b1;
                    gnt_id_d    = pick;
                    last_d      = pick;
                    hold_cnt_d  = 8'd1;
                end else if (!owner_req) begin
                    // Owner released and nobody else is waiting; gnt_id keeps the last owner.
                    state_d    = ST_IDLE;
                    gnt_d      = '0;
                    gnt_vld_d  = 1'b0;
                    hold_cnt_d = 8'd0;
                end else begin
                    // Owner keeps the resource (no competitor, locked, or burst not used up).
                    hold_cnt_d = sat_inc(hold_cnt_q);
                end
            end
            default: begin
                state_d    = ST_IDLE;
                gnt_d      = '0;
                gnt_vld_d  = 1'b0;
                hold_cnt_d = 8'd0;
            end
        endcase
    end

    // State and registered outputs; reset drops any grant on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            gnt_vld_q  <= 1'b0;
            gnt_id_q   <= '0;
            last_q     <= IDW'(N - 1);
            hold_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_vld_q  <= gnt_vld_d;
            gnt_id_q   <= gnt_id_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = gnt_vld_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.hold_cnt  = hold_cnt_q;

endmodule

// File: tb/tb_rr_req_gnt_arbiter.sv
// Testbench for rr_req_gnt_arbiter: directed scenarios plus randomized traffic,
// scored against a behavioural ownership model through an expectation queue.
module tb_rr_req_gnt_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 4;
    localparam int IDW      = $clog2(N);

    logic clk;
    logic rst_i;

    rr_req_gnt_arbiter_if #(.N(N), .IDW(IDW)) bus ();

    rr_req_gnt_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD), .IDW(IDW)) dut (
        .clk (clk),
        .rst (rst_i),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] gnt;
        logic         vld;
        int           id;
        int           cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state: owner index (-1 when idle), rotation pointer, counters.
    int m_owner = -1;
    int m_last  = N - 1;
    int m_id    = 0;
    int m_cnt   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_pick(input logic [N-1:0] r, input int from);
        for (int off = 1; off <= N; off++) begin
            if (r[(from + off) % N]) return (from + off) % N;
        end
        return from;
    endfunction

    task automatic model_step(input logic rs, input logic [N-1:0] r, input logic l);
        exp_t e;
        bit   others;
        int   p;
        if (rs) begin
            m_owner = -1; m_last = N - 1; m_id = 0; m_cnt = 0;
        end else if (m_owner < 0) begin
            if (r != '0) begin
                p = model_pick(r, m_last);
                m_owner = p; m_last = p; m_id = p; m_cnt = 1;
            end
        end else begin
            others = 1'b0;
            for (int i = 0; i < N; i++) if (i != m_owner && r[i]) others = 1'b1;
            if ((!r[m_owner] && others) ||
                (r[m_owner] && MAX_HOLD != 0 && m_cnt >= MAX_HOLD && !l && others)) begin
                p = model_pick(r, m_owner);
                m_owner = p; m_last = p; m_id = p; m_cnt = 1;
            end else if (!r[m_owner]) begin
                m_owner = -1; m_cnt = 0;
            end else begin
                m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
            end
        end
        e.gnt = '0;
        if (m_owner >= 0) e.gnt[m_owner] = 1'b1;
        e.vld = (m_owner >= 0);
        e.id  = m_id;
        e.cnt = m_cnt;
        exp_q.push_back(e);
    endtask

    // Apply one cycle of stimulus away from the sampling edge and record the expected result.
    task automatic drive(input logic rs, input logic [N-1:0] r, input logic l);
        @(negedge clk);
        rst_i    = rs;
        bus.req  = r;
        bus.lock = l;
        model_step(rs, r, l);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        drive(1'b1, '0, 1'b0);
        drive(1'b1, '0, 1'b0);
    endtask

    // Monitor: every edge after stimulus exists, pop the expectation and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("gnt",       int'(bus.gnt),       int'(e.gnt));
                chk("gnt_valid", int'(bus.gnt_valid), int'(e.vld));
                chk("gnt_id",    int'(bus.gnt_id),    e.id);
                chk("hold_cnt",  int'(bus.hold_cnt),  e.cnt);
                chk("gnt_onehot0", int'($onehot0(bus.gnt)), 1);
            end
        end
    end

    initial begin
        logic [N-1:0] r;
        logic         l;
        logic         rs;
        rst_i    = 1'b1;
        bus.req  = '0;
        bus.lock = 1'b0;

        // Reset then single request, then release.
        do_reset();
        drive(1'b0, 4'b0001, 1'b0);
        settle();
        chk("single_gnt", int'(bus.gnt), 1);
        chk("single_hold", int'(bus.hold_cnt), 1);
        repeat (4) drive(1'b0, 4'b0001, 1'b0);
        drive(1'b0, 4'b0000, 1'b0);
        settle();
        chk("release_gnt", int'(bus.gnt), 0);
        chk("release_valid", int'(bus.gnt_valid), 0);

        // Fairness: all requesting, bursts of MAX_HOLD in order 0,1,2,3,0.
        do_reset();
        repeat (20) drive(1'b0, 4'b1111, 1'b0);
        settle();
        chk("fair_wrap_gnt", int'(bus.gnt), 1);
        chk("fair_wrap_hold", int'(bus.hold_cnt), 4);

        // Back-to-back handoff with scan starting after the old owner.
        do_reset();
        drive(1'b0, 4'b0100, 1'b0);
        drive(1'b0, 4'b1001, 1'b0);
        settle();
        chk("b2b_gnt", int'(bus.gnt), 8);
        drive(1'b0, 4'b0001, 1'b0);
        settle();
        chk("b2b_next_gnt", int'(bus.gnt), 1);

        // Lock keeps the owner past MAX_HOLD; dropping lock rotates.
        do_reset();
        drive(1'b0, 4'b0010, 1'b0);
        repeat (9) drive(1'b0, 4'b0011, 1'b1);
        settle();
        chk("lock_gnt", int'(bus.gnt), 2);
        chk("lock_hold", int'(bus.hold_cnt), 10);
        drive(1'b0, 4'b0011, 1'b0);
        settle();
        chk("unlock_gnt", int'(bus.gnt), 1);

        // No competitor: the expired grant is kept.
        do_reset();
        repeat (20) drive(1'b0, 4'b0100, 1'b0);
        settle();
        chk("solo_gnt", int'(bus.gnt), 4);
        chk("solo_hold", int'(bus.hold_cnt), 20);

        // Reset mid-grant, then restart with everyone requesting.
        do_reset();
        repeat (3) drive(1'b0, 4'b1000, 1'b0);
        drive(1'b1, 4'b1000, 1'b0);
        settle();
        chk("rst_mid_gnt", int'(bus.gnt), 0);
        chk("rst_mid_id", int'(bus.gnt_id), 0);
        drive(1'b0, 4'b1111, 1'b0);
        settle();
        chk("rst_restart_gnt", int'(bus.gnt), 1);

        // Randomized traffic with sticky-ish requests, random lock and rare resets.
        r = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) if ($urandom_range(5) == 0) r[i] = ~r[i];
            l  = ($urandom_range(3) == 0);
            rs = ($urandom_range(199) == 0);
            drive(rs, r, l);
        end
        drive(1'b0, '0, 1'b0);

        repeat (3) @(posedge clk);
        #3;
        chk("scoreboard_drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rr_req_gnt_arbiter.md
Name: rr_req_gnt_arbiter

Overview:
- Round-robin arbiter that shares one resource among N requesters using the req/gnt protocol.
- A requester asserts req. The arbiter answers with a registered one-hot gnt exactly one cycle later (req ##1 gnt) when the resource is free.
- A MAX_HOLD burst limit stops one requester from starving the others.
- Sits between requesting agents and the shared resource. Holds ownership state only, no datapath.

Parameters:
- N, 4, number of requesters (2..16).
- MAX_HOLD, 4, maximum consecutive grant cycles while others are waiting; 0 = unlimited.
- IDW, $clog2(N), width of gnt_id.

Ports:
- clk  input  1  single clock, all logic on posedge.
- rst  input  1  synchronous active-high reset.
- req  input  N  per-requester request, level, held until served.
- lock  input  1  owner asks to keep its grant beyond MAX_HOLD; sampled only while a grant is active.
- gnt  output  N  registered one-hot grant (all-zero when idle).
- gnt_valid  output  1  registered, equals |gnt.
- gnt_id  output  IDW  registered index of the current owner; holds the last owner when idle.
- hold_cnt  output  8  registered count of cycles the current owner has held gnt, saturating at 255.

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-high.
- Reset values, applied on the first posedge with rst=1:
  - gnt=0, gnt_valid=0, gnt_id=0, hold_cnt=0.
  - Internal last pointer = N-1, so requester 0 has top priority after reset.
  - State = IDLE.
- rst has priority over all other inputs.
- Reset asserted mid-grant: the grant is dropped on that same edge, with no completion cycle.
- States: IDLE (no owner) and OWN (owner k, gnt[k]=1).
- Pick function: first index i scanning from (last+1) mod N upward, with wrap-around, such that req[i]=1.
- IDLE:
  - If |req at edge t: gnt[pick] is set at t+1; gnt_id=pick; hold_cnt=1; last=pick; go to OWN.
  - Otherwise stay in IDLE with outputs 0.
- OWN, owner k, evaluated each edge:
  - req[k]=0 and another req pending: grant passes to pick (scanning from k+1) on the next edge. Back-to-back, no idle cycle. hold_cnt=1.
  - req[k]=0 and no other req: go to IDLE; gnt=0; hold_cnt=0.
  - req[k]=1, MAX_HOLD!=0, hold_cnt>=MAX_HOLD, lock=0, and another req pending: rotate to pick; hold_cnt=1.
  - req[k]=1, no rotation condition met: keep the grant; hold_cnt increments and saturates at 255.
  - Expired grant with no competitor: keep the grant, counter keeps going.
- lock=1 suppresses only the MAX_HOLD rotation. A req[k] drop always releases the grant.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt[i] is never asserted unless req[i] was high at the previous edge.
  - Any req[i] held continuously without lock is granted within (N-1)*MAX_HOLD+1 cycles when MAX_HOLD>0.
- req[i] deasserted before it is granted is simply ignored; no sticky pending.
- Simultaneous owner drop and new request on the same edge: the new request is eligible, and the grant passes on the next edge.

Test Plan:
- Reset then single request: N=4, rst 2 cycles, req=0001 at t0 → gnt=0001 at t0+1, gnt_id=0, hold_cnt=1; req drops at t5 → gnt=0 and gnt_valid=0 at t6.
- Fairness: req=1111 held, MAX_HOLD=4 → grants 0,1,2,3,0 each lasting 4 cycles, no gaps, one-hot every cycle.
- Back-to-back handoff: owner 2, req=0100→1001 on the same edge → gnt=1000 next cycle (scan from 3), then 0001 after owner 3 releases.
- Lock: owner 1 with lock=1, req=0011 held 10 cycles → gnt stays 0010, hold_cnt reaches 10; lock drops → gnt=0001 next cycle.
- No competitor: req=0100 held 20 cycles, MAX_HOLD=4 → gnt stays 0100, hold_cnt=20.
- Reset mid-grant: owner 3, assert rst → gnt=0 and gnt_id=0 on that edge; release rst with req=1111 → first grant to requester 0.
